// File: rtl/sirv_plic_pkg.sv
// Shared constants for the sirv_plic_mt interrupt controller: register map
// offsets and the per-source gateway state encoding.
package sirv_plic_pkg;

  localparam logic [23:0] PRIO_BASE   = 24'h000000;
  localparam logic [23:0] PEND_BASE   = 24'h001000;
  localparam logic [23:0] EDGE_BASE   = 24'h001800;
  localparam logic [23:0] ENAB_BASE   = 24'h002000;
  localparam logic [23:0] ENAB_STRIDE = 24'h000080;
  localparam logic [23:0] CTX_BASE    = 24'h200000;
  localparam logic [23:0] CTX_STRIDE  = 24'h001000;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PEND     = 2'd1;
  localparam logic [1:0] INFLIGHT = 2'd2;

endpackage

// File: rtl/sirv_plic_gateway.sv
// Per-source interrupt gateway: level/edge qualification, IDLE/PEND/INFLIGHT
// tracking and a one-deep saved edge for edge-mode sources.
module sirv_plic_gateway
  import sirv_plic_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  logic [1:0] state, state_nxt;
  logic       src_q;
  logic       saved, saved_nxt;
  logic       rise, trig;

  assign rise    = src & ~src_q;
  assign trig    = edge_mode ? rise : src;
  assign pending = (state == PEND);

  // An edge arriving together with the complete re-pends without needing the saved flag.
  always_comb begin
    state_nxt = state;
    saved_nxt = saved;
    case (state)
      IDLE: begin
        if (trig) state_nxt = PEND;
      end
      PEND: begin
        if (claim) state_nxt = INFLIGHT;
        if (edge_mode && rise) saved_nxt = 1'b1;
      end
      INFLIGHT: begin
        if (complete) begin
          if (saved) begin
            state_nxt = PEND;
            saved_nxt = edge_mode & rise;
          end else if (trig) begin
            state_nxt = PEND;
            saved_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (edge_mode && rise) begin
          saved_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        saved_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      saved <= 1'b0;
      src_q <= 1'b0;
    end else begin
      state <= state_nxt;
      saved <= saved_nxt;
      src_q <= src;
    end
  end

endmodule

// File: rtl/sirv_plic_mt.sv
// Multi-target PLIC core behind an ICB slave port. Define SIRV_PLIC_IRQ_SYNC_EN
// to put a 2-flop synchroniser on every source line ahead of the gateways.
module sirv_plic_mt
  import sirv_plic_pkg::*;
#(
  parameter int SRC_NUM      = 53,
  parameter int SRC_NUM_LOG2 = 6,
  parameter int TGT_NUM      = 2,
  parameter int PRIO_WIDTH   = 3,
  parameter int RSP_FLOP     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               icb_cmd_valid,
  output logic               icb_cmd_ready,
  input  logic [23:0]        icb_cmd_addr,
  input  logic               icb_cmd_read,
  input  logic [31:0]        icb_cmd_wdata,
  output logic               icb_rsp_valid,
  input  logic               icb_rsp_ready,
  output logic [31:0]        icb_rsp_rdata,
  input  logic [SRC_NUM-1:0] irq_src_i,
  output logic [TGT_NUM-1:0] irq_tgt_o
);

  localparam int SRC_WORDS = (SRC_NUM + 31) / 32;

  logic [PRIO_WIDTH-1:0]   prio [SRC_NUM];
  logic [SRC_NUM-1:0]      edge_mode;
  logic [SRC_NUM-1:0]      enable [TGT_NUM];
  logic [PRIO_WIDTH-1:0]   thr [TGT_NUM];
  logic [PRIO_WIDTH-1:0]   best_prio [TGT_NUM];
  logic [SRC_NUM_LOG2-1:0] max_id [TGT_NUM];
  logic [SRC_NUM_LOG2-1:0] claim_id;
  logic [SRC_NUM-1:0]      src_line, pending, claim_vec, complete_vec;

  logic [23:0] a;
  logic [31:0] prio_idx, word_idx, enab_tgt, enab_word, ctx_tgt;
  logic        hit_prio, hit_pend, hit_edge, hit_enab, hit_ctx;
  logic        cmd_fire, wr_fire, claim_fire, complete_fire;
  logic [31:0] rd_data;

  assign a         = {icb_cmd_addr[23:2], 2'b00};
  assign prio_idx  = {22'd0, a[11:2]};
  assign word_idx  = {23'd0, a[10:2]};
  assign enab_tgt  = {29'd0, a[9:7]};
  assign enab_word = {27'd0, a[6:2]};
  assign ctx_tgt   = {29'd0, a[14:12]};

  assign hit_prio = (a[23:12] == PRIO_BASE[23:12]) && (prio_idx < 32'(SRC_NUM));
  assign hit_pend = (a[23:11] == PEND_BASE[23:11]) && (word_idx < 32'(SRC_WORDS));
  assign hit_edge = (a[23:11] == EDGE_BASE[23:11]) && (word_idx < 32'(SRC_WORDS));
  assign hit_enab = (a[23:10] == ENAB_BASE[23:10]) && (enab_tgt < 32'(TGT_NUM))
                    && (enab_word < 32'(SRC_WORDS));
  assign hit_ctx  = (a[23:15] == CTX_BASE[23:15]) && (ctx_tgt < 32'(TGT_NUM))
                    && (a[11:3] == 9'd0);

  assign cmd_fire      = icb_cmd_valid & icb_cmd_ready;
  assign wr_fire       = cmd_fire & ~icb_cmd_read;
  assign claim_fire    = cmd_fire & icb_cmd_read & hit_ctx & a[2];
  assign complete_fire = wr_fire & hit_ctx & a[2];

`ifdef SIRV_PLIC_IRQ_SYNC_EN
  logic [SRC_NUM-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src_i;
      sync_q2 <= sync_q1;
    end
  end

  assign src_line = sync_q2;
`else
  assign src_line = irq_src_i;
`endif

  // Source 0 has no storage: its bits are reset to 0 and never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SRC_NUM; s++) prio[s] <= '0;
      edge_mode <= '0;
      for (int t = 0; t < TGT_NUM; t++) begin
        enable[t] <= '0;
        thr[t]    <= '0;
      end
    end else if (wr_fire) begin
      for (int s = 1; s < SRC_NUM; s++) begin
        if (hit_prio && prio_idx == 32'(s)) prio[s] <= icb_cmd_wdata[PRIO_WIDTH-1:0];
        if (hit_edge && word_idx == 32'(s / 32)) edge_mode[s] <= icb_cmd_wdata[s % 32];
        for (int t = 0; t < TGT_NUM; t++)
          if (hit_enab && enab_tgt == 32'(t) && enab_word == 32'(s / 32))
            enable[t][s] <= icb_cmd_wdata[s % 32];
      end
      for (int t = 0; t < TGT_NUM; t++)
        if (hit_ctx && !a[2] && ctx_tgt == 32'(t)) thr[t] <= icb_cmd_wdata[PRIO_WIDTH-1:0];
    end
  end

  // Strictly-greater compare while scanning upward gives ties to the lowest ID.
  always_comb begin
    for (int t = 0; t < TGT_NUM; t++) begin
      best_prio[t] = '0;
      max_id[t]    = '0;
      for (int s = 1; s < SRC_NUM; s++) begin
        if (pending[s] && enable[t][s] && prio[s] > thr[t] && prio[s] > best_prio[t]) begin
          best_prio[t] = prio[s];
          max_id[t]    = SRC_NUM_LOG2'(s);
        end
      end
    end
  end

  always_comb begin
    claim_id = '0;
    for (int t = 0; t < TGT_NUM; t++)
      if (ctx_tgt == 32'(t)) claim_id = max_id[t];
  end

  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int s = 1; s < SRC_NUM; s++) begin
      claim_vec[s]    = claim_fire && (claim_id == SRC_NUM_LOG2'(s));
      complete_vec[s] = complete_fire && (icb_cmd_wdata == 32'(s));
    end
  end

  assign pending[0] = 1'b0;

  for (genvar s = 1; s < SRC_NUM; s++) begin : g_gw
    sirv_plic_gateway u_gw (
      .clk       (clk),
      .rst       (rst),
      .src       (src_line[s]),
      .edge_mode (edge_mode[s]),
      .claim     (claim_vec[s]),
      .complete  (complete_vec[s]),
      .pending   (pending[s])
    );
  end

  always_comb begin
    rd_data = '0;
    if (hit_prio)
      for (int s = 0; s < SRC_NUM; s++)
        if (prio_idx == 32'(s)) rd_data[PRIO_WIDTH-1:0] = prio[s];
    if (hit_pend)
      for (int s = 0; s < SRC_NUM; s++)
        if (word_idx == 32'(s / 32)) rd_data[s % 32] = pending[s];
    if (hit_edge)
      for (int s = 0; s < SRC_NUM; s++)
        if (word_idx == 32'(s / 32)) rd_data[s % 32] = edge_mode[s];
    if (hit_enab)
      for (int t = 0; t < TGT_NUM; t++)
        for (int s = 0; s < SRC_NUM; s++)
          if (enab_tgt == 32'(t) && enab_word == 32'(s / 32)) rd_data[s % 32] = enable[t][s];
    if (hit_ctx)
      for (int t = 0; t < TGT_NUM; t++)
        if (ctx_tgt == 32'(t)) rd_data = a[2] ? 32'(max_id[t]) : 32'(thr[t]);
  end

  if (RSP_FLOP != 0) begin : g_rsp_flop
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rsp_valid_q <= 1'b0;
        rsp_rdata_q <= '0;
      end else if (cmd_fire) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= icb_cmd_read ? rd_data : 32'd0;
      end else if (icb_rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end

    assign icb_cmd_ready = ~rsp_valid_q | icb_rsp_ready;
    assign icb_rsp_valid = rsp_valid_q;
    assign icb_rsp_rdata = rsp_rdata_q;
  end else begin : g_rsp_comb
    assign icb_cmd_ready = icb_rsp_ready;
    assign icb_rsp_valid = icb_cmd_valid;
    assign icb_rsp_rdata = icb_cmd_read ? rd_data : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_tgt_o <= '0;
    else
      for (int t = 0; t < TGT_NUM; t++) irq_tgt_o[t] <= (max_id[t] != '0);
  end

  logic unused_bits;
  assign unused_bits = ^{icb_cmd_addr[1:0], src_line[0], claim_vec[0], complete_vec[0]};

endmodule

// File: tb/tb_sirv_plic_mt.sv
// Scoreboard bench for sirv_plic_mt: directed ICB traffic pushes expected read
// data, a negedge monitor pops and compares every accepted response.
module tb_sirv_plic_mt;

  logic        clk = 1'b0;
  logic        rst;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [23:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic        icb_rsp_valid, icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic [52:0] irq_src_i;
  logic [1:0]  irq_tgt_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  sirv_plic_mt dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .irq_src_i     (irq_src_i),
    .irq_tgt_o     (irq_tgt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [23:0] addr, input logic rd, input logic [31:0] wd,
                               input logic [31:0] exp, input string name);
    int n = 0;
    exp_q.push_back(rd ? exp : 32'd0);
    name_q.push_back(name);
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = addr;
    icb_cmd_read  = rd;
    icb_cmd_wdata = wd;
    @(negedge clk);
    while (!icb_cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!icb_cmd_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_accept actual=not_accepted required=accepted", name);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    @(posedge clk);
    #1;
    icb_cmd_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [23:0] addr, input logic [31:0] wd, input string name);
    applyStimulus(addr, 1'b0, wd, 32'd0, name);
  endtask

  task automatic read_reg(input logic [23:0] addr, input logic [31:0] exp, input string name);
    applyStimulus(addr, 1'b1, 32'd0, exp, name);
  endtask

  // A response is consumed at the posedge following a negedge with valid and ready both high.
  always @(negedge clk) begin
    if (!rst && icb_rsp_valid && icb_rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rsp actual=0x%08h required=no_response", icb_rsp_rdata);
      end else begin
        checkOutput(name_q.pop_front(), icb_rsp_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    icb_cmd_valid = 1'b0;
    icb_cmd_addr  = '0;
    icb_cmd_read  = 1'b0;
    icb_cmd_wdata = '0;
    icb_rsp_ready = 1'b1;
    irq_src_i     = '0;
    wait_cycles(2);
    checkOutput("reset_rsp_valid", 32'(icb_rsp_valid), 32'd0);
    checkOutput("reset_rdata", icb_rsp_rdata, 32'd0);
    checkOutput("reset_irq", 32'(irq_tgt_o), 32'd0);
    rst = 1'b0;
    wait_cycles(1);
    read_reg(24'h001000, 32'd0, "reset_pend");
    read_reg(24'h000014, 32'd0, "reset_prio5");

    // Level source 5 on target 0
    write_reg(24'h000014, 32'd3, "wr_prio5");
    write_reg(24'h002000, 32'h20, "wr_en_t0");
    irq_src_i[5] = 1'b1;
    wait_cycles(3);
    checkOutput("lvl_irq_up", 32'(irq_tgt_o), 32'd1);
    read_reg(24'h001000, 32'h20, "lvl_pend_set");
    read_reg(24'h200004, 32'd5, "lvl_claim5");
    read_reg(24'h001000, 32'd0, "lvl_pend_clr");
    wait_cycles(1);
    checkOutput("lvl_irq_drop", 32'(irq_tgt_o), 32'd0);
    write_reg(24'h200004, 32'd5, "lvl_complete5");
    wait_cycles(2);
    checkOutput("lvl_irq_repend", 32'(irq_tgt_o), 32'd1);
    read_reg(24'h200004, 32'd5, "lvl_claim5_again");
    irq_src_i[5] = 1'b0;
    write_reg(24'h200004, 32'd5, "lvl_complete5_low");
    read_reg(24'h001000, 32'd0, "lvl_pend_idle");

    // Edge source 7: two pulses before the claim
    write_reg(24'h001800, 32'h80, "wr_edge7");
    write_reg(24'h00001C, 32'd2, "wr_prio7");
    write_reg(24'h002000, 32'hA0, "wr_en_t0_b");
    for (int i = 0; i < 2; i++) begin
      irq_src_i[7] = 1'b1;
      wait_cycles(1);
      irq_src_i[7] = 1'b0;
      wait_cycles(1);
    end
    read_reg(24'h200004, 32'd7, "edge_claim7");
    read_reg(24'h001000, 32'd0, "edge_pend_clr");
    write_reg(24'h200004, 32'd7, "edge_complete7");
    read_reg(24'h001000, 32'h80, "edge_saved_repend");
    read_reg(24'h200004, 32'd7, "edge_claim7_b");
    write_reg(24'h200004, 32'd7, "edge_complete7_b");
    read_reg(24'h200004, 32'd0, "edge_claim_none");

    // Equal priorities 3 and 9 on target 1, lowest ID first; threshold boundary
    write_reg(24'h00000C, 32'd2, "wr_prio3");
    write_reg(24'h000024, 32'd2, "wr_prio9");
    write_reg(24'h002080, 32'h208, "wr_en_t1");
    write_reg(24'h201000, 32'd1, "wr_thr1");
    irq_src_i[3] = 1'b1;
    irq_src_i[9] = 1'b1;
    wait_cycles(3);
    checkOutput("tie_irq", 32'(irq_tgt_o), 32'd2);
    read_reg(24'h201004, 32'd3, "tie_claim3");
    irq_src_i[3] = 1'b0;
    write_reg(24'h201004, 32'd3, "tie_complete3");
    read_reg(24'h201004, 32'd9, "tie_claim9");
    irq_src_i[9] = 1'b0;
    write_reg(24'h201004, 32'd9, "tie_complete9");
    irq_src_i[3] = 1'b1;
    wait_cycles(3);
    checkOutput("thr_irq_up", 32'(irq_tgt_o), 32'd2);
    write_reg(24'h201000, 32'd2, "wr_thr1_2");
    wait_cycles(2);
    checkOutput("thr_irq_masked", 32'(irq_tgt_o), 32'd0);
    read_reg(24'h201004, 32'd0, "thr_claim_none");
    read_reg(24'h201000, 32'd2, "thr_readback");
    irq_src_i[3] = 1'b0;

    // Source 4 shared by both targets, completed from the other context
    write_reg(24'h000010, 32'd3, "wr_prio4");
    write_reg(24'h002000, 32'hB0, "wr_en_t0_c");
    write_reg(24'h002080, 32'h218, "wr_en_t1_b");
    irq_src_i[4] = 1'b1;
    wait_cycles(3);
    checkOutput("share_irq_both", 32'(irq_tgt_o), 32'd3);
    read_reg(24'h200004, 32'd4, "share_claim_t0");
    irq_src_i[4] = 1'b0;
    read_reg(24'h201004, 32'd0, "share_claim_t1");
    write_reg(24'h201004, 32'd4, "share_complete_t1");
    read_reg(24'h001000, 32'h8, "share_pend");
    read_reg(24'h200004, 32'd0, "share_claim_after");
    write_reg(24'h201004, 32'd3, "complete_not_inflight");
    read_reg(24'h001000, 32'h8, "ignored_complete_pend");
    read_reg(24'h002080, 32'h218, "en_t1_readback");

    // Response back-pressure and unmapped space
    wait_cycles(2);
    icb_rsp_ready = 1'b0;
    read_reg(24'h000014, 32'd3, "stall_read_prio5");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_cmd_ready", 32'(icb_cmd_ready), 32'd0);
      checkOutput("stall_rdata", icb_rsp_rdata, 32'd3);
    end
    @(posedge clk);
    #1;
    icb_rsp_ready = 1'b1;
    read_reg(24'h3FFFFC, 32'd0, "unmapped_read");
    write_reg(24'h0000F0, 32'd7, "wr_prio60_oob");
    read_reg(24'h0000F0, 32'd0, "prio60_oob");
    read_reg(24'h002100, 32'd0, "enab_t2_oob");
    read_reg(24'h202000, 32'd0, "thr_t2_oob");
    read_reg(24'h001008, 32'd0, "pend_w2_oob");

    // Reset while source 6 is in flight and a response is waiting
    write_reg(24'h000018, 32'd1, "wr_prio6");
    write_reg(24'h002000, 32'hF0, "wr_en_t0_d");
    irq_src_i[6] = 1'b1;
    wait_cycles(3);
    read_reg(24'h200004, 32'd6, "rst_claim6");
    irq_src_i[5] = 1'b1;
    wait_cycles(3);
    checkOutput("rst_pre_irq", 32'(irq_tgt_o), 32'd1);
    icb_rsp_ready = 1'b0;
    read_reg(24'h000018, 32'd1, "rst_dropped_rsp");
    checkOutput("rst_pre_rsp_valid", 32'(icb_rsp_valid), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_rsp_valid", 32'(icb_rsp_valid), 32'd0);
    checkOutput("rst_async_rdata", icb_rsp_rdata, 32'd0);
    checkOutput("rst_async_irq", 32'(irq_tgt_o), 32'd0);
    exp_q.delete();
    name_q.delete();
    irq_src_i     = '0;
    icb_rsp_ready = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
    read_reg(24'h001000, 32'd0, "post_rst_pend");
    read_reg(24'h200004, 32'd0, "post_rst_claim");
    read_reg(24'h000018, 32'd0, "post_rst_prio6");
    read_reg(24'h001800, 32'd0, "post_rst_edge");
    read_reg(24'h002000, 32'd0, "post_rst_en_t0");

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL rsp_drain actual=%0d_outstanding required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
